// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares the single-port game-board RAM between the CPU
// load/store path and the display scanner, and zero-fills the board on command.
//
//   state | meaning
//   SERVE | arbitrate CPU/display, one grant per cycle
//   CLEAR | write zero to one cell per cycle, requesters held off
module board_mem_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000,
  parameter int          NUM_CELLS    = 100,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        disp_req,
  input  logic [6:0]  disp_idx,
  output logic        disp_gnt,
  output logic        disp_rvalid,
  output logic [31:0] disp_rdata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int              CW         = $clog2(NUM_CELLS);
  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0]     END_ADDR   = BASE_ADDR + 32'(4 * NUM_CELLS);
  localparam logic [CW-1:0]   LAST_CELL  = CW'(NUM_CELLS - 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {SERVE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clr_cnt_q;
  logic [SW-1:0] starve_q;

  logic          cpu_in_win;
  logic          disp_in_win;
  logic [31:0]   disp_addr;
  logic [31:0]   clr_addr;

  assign cpu_in_win  = (cpu_addr >= BASE_ADDR) && (cpu_addr < END_ADDR);
  assign disp_in_win = (32'(disp_idx) < 32'(NUM_CELLS));
  assign disp_addr   = BASE_ADDR + {23'b0, disp_idx, 2'b00};
  assign clr_addr    = BASE_ADDR + {{(30 - CW){1'b0}}, clr_cnt_q, 2'b00};

  // Next state, grant selection and RAM port drive; reset forces everything idle.
  always_comb begin
    state_d   = state_q;
    cpu_gnt   = 1'b0;
    disp_gnt  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    clr_busy  = 1'b0;
    case (state_q)
      SERVE: begin
        if (clr_start) begin
          state_d = CLEAR;
        end else if ((starve_q == STARVE_MAX) && disp_req) begin
          disp_gnt = 1'b1;
        end else if (cpu_req) begin
          cpu_gnt = 1'b1;
        end else if (disp_req) begin
          disp_gnt = 1'b1;
        end
        if (cpu_gnt) begin
          ram_addr  = {cpu_addr[31:2], 2'b00};
          ram_we    = cpu_we && cpu_in_win;
          ram_wdata = cpu_wdata;
        end else if (disp_gnt) begin
          ram_addr  = disp_addr;
          ram_wdata = cpu_wdata;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_addr;
        if (clr_cnt_q == LAST_CELL) state_d = SERVE;
      end
      default: state_d = SERVE;
    endcase
    if (rst) begin
      state_d   = SERVE;
      cpu_gnt   = 1'b0;
      disp_gnt  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      clr_busy  = 1'b0;
    end
  end

  // State register, clear cell counter and display starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SERVE;
      clr_cnt_q <= '0;
      starve_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) begin
        clr_cnt_q <= (clr_cnt_q == LAST_CELL) ? '0 : clr_cnt_q + 1'b1;
      end else begin
        if (!disp_req || disp_gnt) starve_q <= '0;
        else if (starve_q != STARVE_MAX) starve_q <= starve_q + 1'b1;
      end
    end
  end

  // Read return path: capture at the end of the grant cycle, one-cycle valid/err/done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      cpu_err     <= 1'b0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      clr_done    <= 1'b0;
    end else begin
      cpu_rvalid  <= cpu_gnt && !cpu_we;
      cpu_err     <= cpu_gnt && !cpu_in_win;
      disp_rvalid <= disp_gnt;
      clr_done    <= (state_q == CLEAR) && (clr_cnt_q == LAST_CELL);
      if (cpu_gnt && !cpu_we) cpu_rdata <= cpu_in_win ? ram_rdata : '0;
      if (disp_gnt) disp_rdata <= disp_in_win ? ram_rdata : '0;
    end
  end

endmodule
